// File: rtl/adder_display_pkg.sv
// Shared types, widths and the BCD-to-segment lookup for the adder display path.
package adder_display_pkg;

    localparam int BCD_W = 4;
    localparam int BIN_W = 9;
    // Double-dabble shift register: {hundreds, tens, ones, binary}
    localparam int SH_W  = 3 * BCD_W + BIN_W;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    // Active-high segments, bit 6 = a .. bit 0 = g
    function automatic logic [6:0] seg7(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/adder_display_ctrl_bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by one.
module bcd_dd_step
    import adder_display_pkg::*;
(
    input  logic [SH_W-1:0] din,
    output logic [SH_W-1:0] dout
);

    logic [SH_W-1:0] adj;

    // Correct each BCD nibble, then shift the whole register one place
    always_comb begin
        adj = din;
        for (int i = 0; i < 3; i++) begin
            if (adj[BIN_W + i*BCD_W +: BCD_W] >= 4'd5) begin
                adj[BIN_W + i*BCD_W +: BCD_W] = adj[BIN_W + i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        dout = {adj[SH_W-2:0], 1'b0};
    end

endmodule

// File: rtl/adder_display_ctrl.sv
// Sequencer for the external 8-bit adder and the 3-digit multiplexed 7-segment display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
//
// Handshake: an operand pair transfers on a clock edge where IN_VALID and IN_READY
// are both high; IN_READY is high only in IDLE and IN_VALID is ignored elsewhere.
module adder_display_ctrl
    import adder_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
)
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [7:0]       IN_A,
    input  logic [7:0]       IN_B,
    input  logic             IN_CIN,
    output logic [7:0]       ADD_A,
    output logic [7:0]       ADD_B,
    output logic             ADD_CIN,
    input  logic [7:0]       ADD_SUM,
    input  logic             ADD_COUT,
    output logic             BUSY,
    output logic             RES_VALID,
    output logic [BIN_W-1:0] RES_BIN,
    output logic [BCD_W-1:0] RES_HUND,
    output logic [BCD_W-1:0] RES_TEN,
    output logic [BCD_W-1:0] RES_ONE,
    output logic [2:0]       DIG_SEL,
    output logic [6:0]       SEG,
    output state_t           dbg_state
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t           state;
    state_t           next_state;
    logic [3:0]       iter;
    logic [SH_W-1:0]  sh;
    logic [SH_W-1:0]  step_out;
    logic [BIN_W-1:0] sum_q;
    logic [CNT_W-1:0] scan_cnt;
    logic [BCD_W-1:0] digit;
    logic             blank;

    bcd_dd_step u_step (
        .din  (sh),
        .dout (step_out)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (IN_VALID) next_state = ADD;
            ADD:  next_state = CONV;
            CONV: if (iter == 4'd8) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign IN_READY  = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign RES_VALID = (state == DONE);
    assign dbg_state = state;

    // Operand latch, sum capture, double-dabble iteration and result load
    always_ff @(posedge CLK) begin
        if (RST) begin
            ADD_A    <= '0;
            ADD_B    <= '0;
            ADD_CIN  <= 1'b0;
            sum_q    <= '0;
            sh       <= '0;
            iter     <= '0;
            RES_BIN  <= '0;
            RES_HUND <= '0;
            RES_TEN  <= '0;
            RES_ONE  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        ADD_A   <= IN_A;
                        ADD_B   <= IN_B;
                        ADD_CIN <= IN_CIN;
                    end
                end
                ADD: begin
                    sum_q <= {ADD_COUT, ADD_SUM};
                    sh    <= {{(3*BCD_W){1'b0}}, ADD_COUT, ADD_SUM};
                    iter  <= '0;
                end
                CONV: begin
                    sh   <= step_out;
                    iter <= iter + 4'd1;
                    // Results become visible in DONE, the same cycle RES_VALID is high
                    if (iter == 4'd8) begin
                        RES_BIN  <= sum_q;
                        RES_HUND <= step_out[BIN_W + 2*BCD_W +: BCD_W];
                        RES_TEN  <= step_out[BIN_W + BCD_W +: BCD_W];
                        RES_ONE  <= step_out[BIN_W +: BCD_W];
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running scan counter; digit enable rotates on each wrap
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt <= '0;
            DIG_SEL  <= 3'b001;
        end else if (scan_cnt == CNT_MAX) begin
            scan_cnt <= '0;
            DIG_SEL  <= {DIG_SEL[1:0], DIG_SEL[2]};
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Segment decode of the selected digit (combinational so new results show at once)
    always_comb begin
        case (DIG_SEL)
            3'b100:  digit = RES_HUND;
            3'b010:  digit = RES_TEN;
            default: digit = RES_ONE;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        blank = ((DIG_SEL == 3'b100) && (RES_HUND == '0)) ||
                ((DIG_SEL == 3'b010) && (RES_HUND == '0) && (RES_TEN == '0));
`else
        blank = 1'b0;
`endif
        SEG = blank ? SEG_BLANK : seg7(digit);
    end

endmodule
